// File: rtl/mul_unit_seq.sv
// mul_unit_seq
// Multi-cycle WIDTH x WIDTH -> 2*WIDTH integer multiplier for the execute
// stage. It runs beside the ALU and hands {result_hi, result_lo} back as
// RdHi/RdLo. A valid/ready handshake on both sides lets the control unit
// stall while the multiply is in progress.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   in_valid   operands/op valid
//   in_ready   unit can accept (high only while idle)
//   op         000 MUL, 001 UMULL, 010 SMULL, 100 UMLAL, 101 SMLAL, others MUL
//   a, b       operands (two's complement for signed ops)
//   acc        {hi,lo} accumulator for the *MLAL ops
//   out_valid  result valid, held until accepted
//   out_ready  consumer accepts result
//   result_lo  low half of result
//   result_hi  high half of result (0 for MUL)
//   flags      {N,Z,C,V}; C and V are always 0
//
// Build option
//   MUL_ACCUMULATE_EN  when defined, ops 100/101 add acc to the product.
//                      When undefined they behave as UMULL/SMULL and acc
//                      is ignored. The acc port exists in both builds.
module mul_unit_seq #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [2*WIDTH-1:0] acc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result_lo,
  output logic [WIDTH-1:0]   result_hi,
  output logic [3:0]         flags
);

  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, CALC, FINAL, DONE} state_t;

  state_t state, state_nxt;

  logic               op_is_long;
  logic               op_is_signed;
  logic               op_is_acc;
  logic [WIDTH-1:0]   a_mag_in;
  logic [WIDTH-1:0]   b_mag_in;

  logic [2*WIDTH-1:0] a_sh;
  logic [WIDTH-1:0]   b_sh;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_step;
  logic [2*WIDTH-1:0] prod_signed;
  logic [2*WIDTH-1:0] final_val;
  logic [CW-1:0]      cnt;
  logic               neg_q;
  logic               long_q;

`ifdef MUL_ACCUMULATE_EN
  logic [2*WIDTH-1:0] acc_q;
  logic               acc_en_q;
`else
  logic               unused_acc;
  assign unused_acc = ^acc;
`endif

  // Decode the incoming op. Unlisted encodings fall back to plain MUL.
  // The accumulate ops collapse to their non-accumulating long forms when
  // the accumulate build option is off.
  always_comb begin
    op_is_long   = (op == 3'b001) || (op == 3'b010) ||
                   (op == 3'b100) || (op == 3'b101);
    op_is_signed = (op == 3'b010) || (op == 3'b101);
`ifdef MUL_ACCUMULATE_EN
    op_is_acc    = (op == 3'b100) || (op == 3'b101);
`else
    op_is_acc    = 1'b0;
`endif
  end

  // Shift-add runs on magnitudes. Negating the most-negative value gives
  // the same bit pattern, and that pattern read as unsigned is exactly
  // 2^(WIDTH-1). So no extra bit is needed.
  always_comb begin
    a_mag_in = (op_is_signed && a[WIDTH-1]) ? -a : a;
    b_mag_in = (op_is_signed && b[WIDTH-1]) ? -b : b;
  end

  // One CALC step retires BITS_PER_CYCLE multiplier bits. The multiplicand
  // is pre-shifted, so bit i of b_sh adds a_sh << i.
  always_comb begin
    prod_step = prod;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (b_sh[i]) begin
        prod_step = prod_step + (a_sh << i);
      end
    end
  end

  // Final result: apply the sign fix first, then add the accumulator.
  // The sum wraps modulo 2^(2*WIDTH).
  always_comb begin
    prod_signed = neg_q ? -prod : prod;
`ifdef MUL_ACCUMULATE_EN
    final_val   = prod_signed + (acc_en_q ? acc_q : '0);
`else
    final_val   = prod_signed;
`endif
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and handshake outputs. in_valid is only looked at in IDLE,
  // so requests made while busy or while holding a result are dropped.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = CALC;
      end
      CALC: begin
        if (cnt == '0) state_nxt = FINAL;
      end
      FINAL: begin
        state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath. Operands are latched on accept and the product builds up
  // during CALC. The visible result and flags change only in FINAL, so they
  // stay stable through DONE for as long as the consumer stalls.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_sh      <= '0;
      b_sh      <= '0;
      prod      <= '0;
      cnt       <= '0;
      neg_q     <= 1'b0;
      long_q    <= 1'b0;
      result_lo <= '0;
      result_hi <= '0;
      flags     <= '0;
`ifdef MUL_ACCUMULATE_EN
      acc_q     <= '0;
      acc_en_q  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh     <= {{WIDTH{1'b0}}, a_mag_in};
            b_sh     <= b_mag_in;
            prod     <= '0;
            cnt      <= CW'(N - 1);
            neg_q    <= op_is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
            long_q   <= op_is_long;
`ifdef MUL_ACCUMULATE_EN
            acc_q    <= acc;
            acc_en_q <= op_is_acc;
`endif
          end
        end
        CALC: begin
          prod <= prod_step;
          a_sh <= a_sh << BITS_PER_CYCLE;
          b_sh <= b_sh >> BITS_PER_CYCLE;
          cnt  <= cnt - CW'(1);
        end
        FINAL: begin
          result_lo <= final_val[WIDTH-1:0];
          result_hi <= long_q ? final_val[2*WIDTH-1:WIDTH] : '0;
          if (long_q) begin
            flags <= {final_val[2*WIDTH-1], (final_val == '0), 2'b00};
          end else begin
            flags <= {final_val[WIDTH-1], (final_val[WIDTH-1:0] == '0), 2'b00};
          end
        end
        default: ;
      endcase
    end
  end

endmodule
